fft_frame_ctrl: RTL and testbench

//  Frame sequencer in front of and behind the R2SDF FFT stage chain (first..fifth_stage).

---
 rtl/fft_frame_ctrl.sv | 143 ++++++++++++++
 tb/tb_fft_frame_ctrl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_frame_ctrl.sv
// Frame sequencer around the R2SDF FFT stage chain: admits one N-point frame, tags results, recovers from stalls.
// Optional FFT_BITREV_IDX_EN: report oOut_idx as the bit-reversed arrival count (natural bin order).
module fft_frame_ctrl #(
    parameter int LOG2N   = 5,
    parameter int IW      = 33,
    parameter int OW      = 36,
    parameter int TIMEOUT = 1024
) (
    input  logic             iClk,
    input  logic             Rst,
    input  logic             iIn_valid,
    output logic             oIn_ready,
    input  logic [IW-1:0]    iIn_Re,
    input  logic [IW-1:0]    iIn_Im,
    output logic             oPipe_valid,
    output logic [IW-1:0]    oPipe_Re,
    output logic [IW-1:0]    oPipe_Im,
    output logic             oPipe_rst_n,
    input  logic             iPipe_valid,
    input  logic [OW-1:0]    iPipe_Re,
    input  logic [OW-1:0]    iPipe_Im,
    output logic             oOut_valid,
    output logic [OW-1:0]    oOut_Re,
    output logic [OW-1:0]    oOut_Im,
    output logic             oOut_sop,
    output logic             oOut_eop,
    output logic [LOG2N-1:0] oOut_idx,
    output logic             oBusy,
    output logic             oErr
);

    localparam int N  = 2 ** LOG2N;
    localparam int CW = LOG2N + 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, LOAD, DRAIN, CLEAR} state_t;

    state_t        state, stateNext;
    logic [CW-1:0] inCnt, outCnt;
    logic [TW-1:0] idleCnt;
    logic          clrCnt;
    logic          runQ;
    logic          accept, inFrame, lastIn, lastOut, resultHit, timeoutHit, strayResult;

`ifdef FFT_BITREV_IDX_EN
    function automatic logic [LOG2N-1:0] bitRev(input logic [LOG2N-1:0] v);
        logic [LOG2N-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < LOG2N; i++) r[i] = v[LOG2N-1-i];
        return r;
    endfunction
`endif

    always_ff @(posedge iClk or posedge Rst) begin
        if (Rst) state <= IDLE;
        else     state <= stateNext;
    end

    always_comb begin
        stateNext   = state;
        oBusy       = (state != IDLE);
        // runQ keeps ready low while reset is held and until the first clock after it
        oIn_ready   = runQ && (state == IDLE || state == LOAD);
        accept      = iIn_valid && oIn_ready;
        inFrame     = (state == LOAD || state == DRAIN);
        lastIn      = (inCnt == CW'(N - 1));
        lastOut     = (outCnt == CW'(N - 1));
        resultHit   = inFrame && iPipe_valid;
        timeoutHit  = inFrame && !accept && !iPipe_valid && (idleCnt == TW'(TIMEOUT - 1));
        strayResult = iPipe_valid && (state == IDLE || state == CLEAR);
        case (state)
            IDLE:  if (accept) stateNext = LOAD;
            LOAD: begin
                if (timeoutHit)           stateNext = CLEAR;
                else if (accept && lastIn) stateNext = DRAIN;
            end
            DRAIN: begin
                if (timeoutHit)             stateNext = CLEAR;
                else if (resultHit && lastOut) stateNext = IDLE;
            end
            CLEAR: if (clrCnt) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge iClk or posedge Rst) begin
        if (Rst) begin
            runQ        <= 1'b0;
            oPipe_rst_n <= 1'b0;
            clrCnt      <= 1'b0;
            inCnt       <= '0;
            outCnt      <= '0;
            idleCnt     <= '0;
            oPipe_valid <= 1'b0;
            oPipe_Re    <= '0;
            oPipe_Im    <= '0;
            oOut_valid  <= 1'b0;
            oOut_Re     <= '0;
            oOut_Im     <= '0;
            oOut_sop    <= 1'b0;
            oOut_eop    <= 1'b0;
            oOut_idx    <= '0;
            oErr        <= 1'b0;
        end else begin
            runQ        <= 1'b1;
            // pipe clear follows the state register so it is low exactly for the CLEAR cycles
            oPipe_rst_n <= (stateNext != CLEAR);
            clrCnt      <= (state == CLEAR) ? ~clrCnt : 1'b0;

            if (state == CLEAR)                inCnt <= '0;
            else if (state == IDLE && accept)  inCnt <= CW'(1);
            else if (state == LOAD && accept)  inCnt <= inCnt + CW'(1);

            if (resultHit)                                      outCnt <= lastOut ? '0 : outCnt + CW'(1);
            else if (state == CLEAR || (state == IDLE && accept)) outCnt <= '0;

            if (inFrame && !accept && !iPipe_valid) idleCnt <= idleCnt + TW'(1);
            else                                    idleCnt <= '0;

            oPipe_valid <= accept;
            if (accept) begin
                oPipe_Re <= iIn_Re;
                oPipe_Im <= iIn_Im;
            end

            oOut_valid <= resultHit;
            oOut_sop   <= resultHit && (outCnt == '0);
            oOut_eop   <= resultHit && lastOut;
            if (resultHit) begin
                oOut_Re <= iPipe_Re;
                oOut_Im <= iPipe_Im;
`ifdef FFT_BITREV_IDX_EN
                oOut_idx <= bitRev(outCnt[LOG2N-1:0]);
`else
                oOut_idx <= outCnt[LOG2N-1:0];
`endif
            end

            if (timeoutHit || strayResult) oErr <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Directed bench for fft_frame_ctrl: full frames, gapped input, EOP/input overlap, timeout, stray result, mid-frame reset.
module tb_fft_frame_ctrl;

    localparam int LOG2N   = 5;
    localparam int IW      = 33;
    localparam int OW      = 36;
    localparam int TIMEOUT = 1024;
    localparam int N       = 32;

    logic             iClk = 1'b0;
    logic             Rst;
    logic             iIn_valid;
    logic             oIn_ready;
    logic [IW-1:0]    iIn_Re, iIn_Im;
    logic             oPipe_valid;
    logic [IW-1:0]    oPipe_Re, oPipe_Im;
    logic             oPipe_rst_n;
    logic             iPipe_valid;
    logic [OW-1:0]    iPipe_Re, iPipe_Im;
    logic             oOut_valid;
    logic [OW-1:0]    oOut_Re, oOut_Im;
    logic             oOut_sop, oOut_eop;
    logic [LOG2N-1:0] oOut_idx;
    logic             oBusy, oErr;

    int nCmp = 0;
    int nErr = 0;

    fft_frame_ctrl #(.LOG2N(LOG2N), .IW(IW), .OW(OW), .TIMEOUT(TIMEOUT)) dut (
        .iClk(iClk), .Rst(Rst),
        .iIn_valid(iIn_valid), .oIn_ready(oIn_ready), .iIn_Re(iIn_Re), .iIn_Im(iIn_Im),
        .oPipe_valid(oPipe_valid), .oPipe_Re(oPipe_Re), .oPipe_Im(oPipe_Im), .oPipe_rst_n(oPipe_rst_n),
        .iPipe_valid(iPipe_valid), .iPipe_Re(iPipe_Re), .iPipe_Im(iPipe_Im),
        .oOut_valid(oOut_valid), .oOut_Re(oOut_Re), .oOut_Im(oOut_Im),
        .oOut_sop(oOut_sop), .oOut_eop(oOut_eop), .oOut_idx(oOut_idx),
        .oBusy(oBusy), .oErr(oErr)
    );

    always #5 iClk = ~iClk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no end of run, expected finish before 200000");
        $fatal(1);
    end

    task automatic tick();
        @(posedge iClk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nCmp++;
        assert (obs === exp) else begin
            nErr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [LOG2N-1:0] expIdx(input int k);
        logic [LOG2N-1:0] v;
        logic [LOG2N-1:0] r;
        v = LOG2N'(k);
        r = v;
`ifdef FFT_BITREV_IDX_EN
        for (int i = 0; i < LOG2N; i++) r[i] = v[LOG2N-1-i];
`endif
        return r;
    endfunction

    task automatic checkReset();
        chk("rst_ready",  64'(oIn_ready),   64'(0));
        chk("rst_pipeRn", 64'(oPipe_rst_n), 64'(0));
        chk("rst_pipeV",  64'(oPipe_valid), 64'(0));
        chk("rst_pipeRe", 64'(oPipe_Re),    64'(0));
        chk("rst_outV",   64'(oOut_valid),  64'(0));
        chk("rst_outRe",  64'(oOut_Re),     64'(0));
        chk("rst_sop",    64'(oOut_sop),    64'(0));
        chk("rst_busy",   64'(oBusy),       64'(0));
        chk("rst_err",    64'(oErr),        64'(0));
    endtask

    task automatic doReset();
        Rst = 1'b1;
        #2;
        checkReset();
        @(posedge iClk);
        #1 Rst = 1'b0;
        tick();
        chk("post_rst_pipeRn", 64'(oPipe_rst_n), 64'(1));
        chk("post_rst_ready",  64'(oIn_ready),   64'(1));
    endtask

    initial begin
        logic [IW-1:0] eRe, eIm;
        logic [OW-1:0] eO;
        int pulses;
        int k;

        Rst = 1'b1; iIn_valid = 1'b0; iIn_Re = '0; iIn_Im = '0;
        iPipe_valid = 1'b0; iPipe_Re = '0; iPipe_Im = '0;
        #3;
        doReset();

        // Frame A: 32 back-to-back samples, results arrive 40 cycles after the first
        for (int t = 0; t < 72; t++) begin
            iIn_valid   = (t < 32);
            iIn_Re      = IW'(t * 3 + 1);
            iIn_Im      = -IW'(t);
            iPipe_valid = (t >= 40);
            iPipe_Re    = OW'(100 + t - 40);
            iPipe_Im    = OW'(2 * (t - 40));
            tick();
            chk("A_pipeV", 64'(oPipe_valid), 64'(t < 32));
            if (t < 32) begin
                eRe = IW'(t * 3 + 1); eIm = -IW'(t);
                chk("A_pipeRe", 64'(oPipe_Re), 64'(eRe));
                chk("A_pipeIm", 64'(oPipe_Im), 64'(eIm));
            end
            chk("A_ready", 64'(oIn_ready), 64'((t < 31) || (t >= 71)));
            chk("A_busy",  64'(oBusy),     64'(t < 71));
            chk("A_outV",  64'(oOut_valid), 64'(t >= 40));
            if (t >= 40) begin
                k  = t - 40;
                eO = OW'(100 + k);
                chk("A_outRe", 64'(oOut_Re),  64'(eO));
                eO = OW'(2 * k);
                chk("A_outIm", 64'(oOut_Im),  64'(eO));
                chk("A_sop",   64'(oOut_sop), 64'(k == 0));
                chk("A_eop",   64'(oOut_eop), 64'(k == 31));
                chk("A_idx",   64'(oOut_idx), 64'(expIdx(k)));
            end
        end
        iIn_valid = 1'b0; iPipe_valid = 1'b0;
        tick();
        chk("A_idle_outV", 64'(oOut_valid), 64'(0));
        chk("A_idle_busy", 64'(oBusy),      64'(0));
        chk("A_idle_err",  64'(oErr),       64'(0));

        // Frame B: valid toggling, pipe output must hold between accepts
        pulses = 0;
        for (int t = 0; t < 64; t++) begin
            iIn_valid = (t % 2 == 0);
            iIn_Re    = (t % 2 == 0) ? IW'(1000 + t / 2) : IW'(12345);
            iIn_Im    = IW'(t / 2);
            tick();
            if (oPipe_valid) pulses++;
            chk("B_pipeV", 64'(oPipe_valid), 64'(t % 2 == 0));
            eRe = IW'(1000 + t / 2);
            chk("B_pipeRe", 64'(oPipe_Re), 64'(eRe));
            chk("B_ready",  64'(oIn_ready), 64'(t < 62));
        end
        chk("B_pulses", 64'(pulses), 64'(32));

        // Drain B; the last result coincides with a new sample, which must wait a cycle
        for (int j = 0; j < N; j++) begin
            iPipe_valid = 1'b1;
            iPipe_Re    = OW'(500 + j);
            iPipe_Im    = '0;
            iIn_valid   = (j == N - 1);
            iIn_Re      = IW'(777);
            tick();
            chk("B_outV",   64'(oOut_valid),  64'(1));
            eO = OW'(500 + j);
            chk("B_outRe",  64'(oOut_Re),     64'(eO));
            chk("B_eop",    64'(oOut_eop),    64'(j == N - 1));
            chk("B_pipeV2", 64'(oPipe_valid), 64'(0));
            chk("B_ready2", 64'(oIn_ready),   64'(j == N - 1));
        end
        iPipe_valid = 1'b0;
        tick();
        chk("C_first_pipeV",  64'(oPipe_valid), 64'(1));
        eRe = IW'(777);
        chk("C_first_pipeRe", 64'(oPipe_Re),    64'(eRe));
        chk("C_first_busy",   64'(oBusy),       64'(1));
        chk("C_first_outV",   64'(oOut_valid),  64'(0));

        // Frame C completes loading, then the pipe never answers
        for (int j = 1; j < N; j++) begin
            iIn_Re = IW'(800 + j);
            tick();
        end
        iIn_valid = 1'b0;
        chk("C_ready_full", 64'(oIn_ready), 64'(0));
        repeat (TIMEOUT - 1) tick();
        chk("C_pre_err",   64'(oErr),        64'(0));
        chk("C_pre_busy",  64'(oBusy),       64'(1));
        chk("C_pre_rn",    64'(oPipe_rst_n), 64'(1));
        tick();
        chk("C_to_err",    64'(oErr),        64'(1));
        chk("C_to_rn1",    64'(oPipe_rst_n), 64'(0));
        chk("C_to_ready",  64'(oIn_ready),   64'(0));
        chk("C_to_eop",    64'(oOut_eop),    64'(0));
        tick();
        chk("C_to_rn2",    64'(oPipe_rst_n), 64'(0));
        chk("C_to_ready2", 64'(oIn_ready),   64'(0));
        tick();
        chk("C_rn_back",   64'(oPipe_rst_n), 64'(1));
        chk("C_idle_rdy",  64'(oIn_ready),   64'(1));
        chk("C_idle_busy", 64'(oBusy),       64'(0));
        chk("C_err_stick", 64'(oErr),        64'(1));

        // Stray result in IDLE
        doReset();
        iPipe_valid = 1'b1; iPipe_Re = OW'(5);
        tick();
        iPipe_valid = 1'b0;
        chk("X_outV", 64'(oOut_valid), 64'(0));
        chk("X_err",  64'(oErr),       64'(1));
        chk("X_busy", 64'(oBusy),      64'(0));

        doReset();

        // Reset after 10 accepts, then a fresh frame must need all 32 samples
        iIn_valid = 1'b1;
        for (int j = 0; j < 10; j++) begin
            iIn_Re = IW'(50 + j);
            tick();
        end
        iIn_valid = 1'b0;
        chk("R_busy_pre", 64'(oBusy), 64'(1));
        doReset();
        for (int j = 0; j < N; j++) begin
            iIn_valid = 1'b1;
            iIn_Re    = IW'(60 + j);
            tick();
            chk("D_ready", 64'(oIn_ready), 64'(j < N - 1));
        end
        iIn_valid = 1'b0;
        for (int j = 0; j < N; j++) begin
            iPipe_valid = 1'b1;
            iPipe_Re    = OW'(900 + j);
            tick();
            chk("D_outV", 64'(oOut_valid), 64'(1));
            chk("D_sop",  64'(oOut_sop),   64'(j == 0));
            chk("D_eop",  64'(oOut_eop),   64'(j == N - 1));
            chk("D_idx",  64'(oOut_idx),   64'(expIdx(j)));
        end
        iPipe_valid = 1'b0;
        tick();
        chk("D_busy_end", 64'(oBusy), 64'(0));
        chk("D_err_end",  64'(oErr),  64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end

endmodule
